// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side signal bundle for the hazard/pipeline-control unit.
//
// Signals
//   ir_d           instruction in decode/execute (consumer)
//   ir_m           instruction in memory/writeback (producer)
//   reg_wr_m       ir_m writes the register file
//   br_taken       branch/jump resolved taken this cycle
//   dbg_halt_req   debugger halt request, level-sensitive
//   dbg_resume_req debugger resume request, single-cycle pulse
//   for_a, for_b   forwarding selects for rs1 / rs2
//   stall          hold PC and IF/ID, insert a bubble
//   flush          squash younger instructions
//   dbg_halted     core frozen for the debugger
//   dbg_state      current control FSM state, for observation only
//
// Handshake: there is no valid/ready pair on this bundle. Every input is
// sampled on each rising clock edge; stall/flush are consumed by the
// pipeline in the same cycle they are asserted. The debug pair is a
// request/acknowledge: dbg_halt_req is held until dbg_halted is seen,
// dbg_resume_req is a one-cycle pulse answered by dbg_halted falling.
//
// Modports: master = pipeline/debugger side, slave = hazard_ctrl.
interface hazard_ctrl_if;
    logic [31:0] ir_d;
    logic [31:0] ir_m;
    logic        reg_wr_m;
    logic        br_taken;
    logic        dbg_halt_req;
    logic        dbg_resume_req;
    logic        for_a;
    logic        for_b;
    logic        stall;
    logic        flush;
    logic        dbg_halted;
    logic [1:0]  dbg_state;

    modport master (
        output ir_d, ir_m, reg_wr_m, br_taken, dbg_halt_req, dbg_resume_req,
        input  for_a, for_b, stall, flush, dbg_halted, dbg_state
    );

    modport slave (
        input  ir_d, ir_m, reg_wr_m, br_taken, dbg_halt_req, dbg_resume_req,
        output for_a, for_b, stall, flush, dbg_halted, dbg_state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding / load-use stall / branch flush / debug halt control
// for the MASF-RV pipeline.
//
// Parameters
//   LOAD_STALL  (1..7) stall cycles per load-use hazard
//   FLUSH_DEPTH (1..7) cycles flush is held after a taken branch
//
// Ports
//   clk  single clock
//   rst  synchronous, active-high reset
//   bus  hazard_ctrl_if.slave (instructions, branch/debug inputs,
//        forwarding/stall/flush/halt outputs, dbg_state)
//
// Build option
//   HAZARD_FWD_EN  when defined, RAW hazards on non-load producers are
//                  resolved by forwarding. When undefined, for_a/for_b are
//                  tied low and every RAW hazard against ir_m stalls.
module hazard_ctrl #(
    parameter int LOAD_STALL  = 1,
    parameter int FLUSH_DEPTH = 1
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2,
        HALT   = 2'd3
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    // The first stall/flush cycle is spent in RUN, so the counters only
    // cover the remaining cycles.
    localparam logic [2:0] LS_RELOAD = 3'(LOAD_STALL - 1);
    localparam logic [2:0] FD_RELOAD = 3'(FLUSH_DEPTH - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       halt_pend_q, halt_pend_d;

    logic [6:0] op_d;
    logic [4:0] rs1, rs2, rd_m;
    logic       is_load, use_rs1, use_rs2, match_a, match_b, hz;
    logic       stall_o, flush_o, halted_o, for_a_o, for_b_o;

    // Field decode and hazard terms
    always_comb begin
        op_d    = bus.ir_d[6:0];
        rs1     = bus.ir_d[19:15];
        rs2     = bus.ir_d[24:20];
        rd_m    = bus.ir_m[11:7];
        is_load = (bus.ir_m[6:0] == OP_LOAD);
        use_rs1 = !((op_d == OP_LUI) || (op_d == OP_AUIPC) || (op_d == OP_JAL));
        use_rs2 = (op_d == OP_R) || (op_d == OP_S) || (op_d == OP_B);
        match_a = use_rs1 && (rs1 != 5'd0) && (rs1 == rd_m) && bus.reg_wr_m;
        match_b = use_rs2 && (rs2 != 5'd0) && (rs2 == rd_m) && bus.reg_wr_m;
`ifdef HAZARD_FWD_EN
        hz = is_load && (match_a || match_b);
`else
        hz = match_a || match_b;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= 3'd0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // Next-state logic; priority br_taken > load-use > halt
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        halt_pend_d = halt_pend_q;
        case (state_q)
            RUN: begin
                if (bus.br_taken) begin
                    if (FLUSH_DEPTH > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FD_RELOAD;
                    end
                end else if (hz) begin
                    if (LOAD_STALL > 1) begin
                        state_d = LSTALL;
                        cnt_d   = LS_RELOAD;
                    end
                end else if (bus.dbg_halt_req || halt_pend_q) begin
                    state_d     = HALT;
                    halt_pend_d = 1'b0;
                end
            end
            LSTALL: begin
                if (bus.dbg_halt_req) halt_pend_d = 1'b1;
                if (bus.br_taken) begin
                    // Branch aborts the stall and starts a fresh flush
                    if (FLUSH_DEPTH > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FD_RELOAD;
                    end else begin
                        state_d = RUN;
                        cnt_d   = 3'd0;
                    end
                end else if (cnt_q <= 3'd1) begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            FLUSH: begin
                if (bus.dbg_halt_req) halt_pend_d = 1'b1;
                if (bus.br_taken) begin
                    cnt_d = FD_RELOAD;
                end else if (cnt_q <= 3'd1) begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            HALT: begin
                // Resume wins over a still-asserted halt request
                if (bus.dbg_resume_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs
    always_comb begin
        stall_o  = 1'b0;
        flush_o  = 1'b0;
        halted_o = 1'b0;
        case (state_q)
            RUN: begin
                flush_o = bus.br_taken;
                stall_o = !bus.br_taken && hz;
            end
            LSTALL: begin
                flush_o = bus.br_taken;
                stall_o = !bus.br_taken;
            end
            FLUSH: flush_o = 1'b1;
            HALT: begin
                stall_o  = 1'b1;
                halted_o = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            stall_o  = 1'b0;
            flush_o  = 1'b0;
            halted_o = 1'b0;
        end
`ifdef HAZARD_FWD_EN
        for_a_o = match_a && !is_load && (state_q != HALT) && !flush_o;
        for_b_o = match_b && !is_load && (state_q != HALT) && !flush_o;
`else
        for_a_o = 1'b0;
        for_b_o = 1'b0;
`endif
    end

    assign bus.for_a      = for_a_o;
    assign bus.for_b      = for_b_o;
    assign bus.stall      = stall_o;
    assign bus.flush      = flush_o;
    assign bus.dbg_halted = halted_o;
    assign bus.dbg_state  = state_q;

    // Instruction bits the control logic never looks at
    logic unused_bits;
`ifdef HAZARD_FWD_EN
    assign unused_bits = ^{bus.ir_d[31:25], bus.ir_d[14:7], bus.ir_m[31:12]};
`else
    assign unused_bits = ^{bus.ir_d[31:25], bus.ir_d[14:7], bus.ir_m[31:12], is_load};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl with LOAD_STALL=3,
// FLUSH_DEPTH=2. A driver issues one input vector per cycle and pushes the
// hand-computed output word {for_a, for_b, stall, flush, dbg_halted} into a
// queue; a monitor on the falling edge pops and compares each cycle.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] LUI_X7 = {7'd0, 5'd7, 5'd7, 3'd0, 5'd7, 7'b0110111};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if bus ();

    hazard_ctrl #(
        .LOAD_STALL (3),
        .FLUSH_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- scoreboard ----------------
    logic [4:0] exp_q[$];
    string      name_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [4:0] e;
            logic [4:0] act;
            string      nm;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {bus.for_a, bus.for_b, bus.stall, bus.flush, bus.dbg_halted};
            n_tests++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got {fa,fb,st,fl,h}=%b expected %b", nm, act, e);
            end
        end
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] r1,
                                          input logic [4:0] r2);
        return {7'd0, r2, r1, 3'd0, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] r1);
        return {12'd0, r1, 3'b010, rd, 7'b0000011};
    endfunction

    // ---------------- driver ----------------
    task automatic step(input string nm, input bit r, input logic [31:0] d,
                        input logic [31:0] m, input bit wr, input bit br,
                        input bit hq, input bit hr, input logic [4:0] e);
        @(posedge clk);
        #1;
        rst                = r;
        bus.ir_d           = d;
        bus.ir_m           = m;
        bus.reg_wr_m       = wr;
        bus.br_taken       = br;
        bus.dbg_halt_req   = hq;
        bus.dbg_resume_req = hr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic idle(input string nm, input logic [4:0] e);
        step(nm, 1'b0, NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, e);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] add5;
        logic [31:0] lw5;
        logic [31:0] use55;
        logic [4:0]  tail;
        add5  = enc_r(5'd5, 5'd1, 5'd2);
        lw5   = enc_lw(5'd5, 5'd1);
        use55 = enc_r(5'd6, 5'd5, 5'd5);
        // without forwarding the add producer costs three stall cycles
        tail  = FWD ? 5'b00000 : 5'b00100;

        bus.ir_d = NOP; bus.ir_m = NOP; bus.reg_wr_m = 1'b0; bus.br_taken = 1'b0;
        bus.dbg_halt_req = 1'b0; bus.dbg_resume_req = 1'b0;

        // reset: control outputs low, forwarding still combinational
        step("rst_fwd", 1'b1, use55, add5, 1'b1, 1'b0, 1'b0, 1'b0,
             FWD ? 5'b11000 : 5'b00000);
        step("rst_idle", 1'b1, NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);
        idle("idle", 5'b00000);

        // both operands from an add producer
        step("fwd_ab", 1'b0, use55, add5, 1'b1, 1'b0, 1'b0, 1'b0,
             FWD ? 5'b11000 : 5'b00100);
        idle("fwd_ab_t1", tail);
        idle("fwd_ab_t2", tail);
        idle("fwd_ab_end", 5'b00000);

        // rs2 only
        step("fwd_b", 1'b0, enc_r(5'd6, 5'd1, 5'd5), add5, 1'b1, 1'b0, 1'b0, 1'b0,
             FWD ? 5'b01000 : 5'b00100);
        idle("fwd_b_t1", tail);
        idle("fwd_b_t2", tail);
        idle("fwd_b_end", 5'b00000);

        // x0 never matches, unused operands never match, no write no match
        step("x0_prod", 1'b0, enc_r(5'd3, 5'd0, 5'd0), enc_r(5'd0, 5'd1, 5'd2),
             1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);
        step("x0_dst", 1'b0, enc_r(5'd3, 5'd1, 5'd2), enc_r(5'd0, 5'd1, 5'd2),
             1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);
        step("lui_x7", 1'b0, LUI_X7, enc_r(5'd7, 5'd1, 5'd2),
             1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);
        step("lui_x0", 1'b0, LUI_X7, enc_r(5'd0, 5'd1, 5'd2),
             1'b1, 1'b0, 1'b0, 1'b0, 5'b00000);
        step("no_wr", 1'b0, use55, add5, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);

        // load-use: exactly three stall cycles, no forwarding
        step("lu_1", 1'b0, use55, lw5, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00100);
        idle("lu_2", 5'b00100);
        idle("lu_3", 5'b00100);
        idle("lu_end", 5'b00000);

        // branch in the 2nd stall cycle: two flush cycles, stall dropped
        step("bs_1", 1'b0, use55, lw5, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00100);
        step("bs_br", 1'b0, NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00010);
        step("bs_fl2", 1'b0, use55, add5, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010);
        idle("bs_run", 5'b00000);

        // halt requested during flush is deferred until after RUN returns
        step("hf_br", 1'b0, NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00010);
        step("hf_req", 1'b0, NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00010);
        idle("hf_run", 5'b00000);
        idle("hf_halt", 5'b00101);
        step("hf_nofwd", 1'b0, use55, add5, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00101);
        step("hf_res", 1'b0, NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00101);
        idle("hf_out", 5'b00000);
        idle("hf_clr", 5'b00000);

        // direct halt; halt and resume together -> resume wins
        step("hd_req", 1'b0, NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000);
        step("hd_halt", 1'b0, NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00101);
        step("hd_both", 1'b0, NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00101);
        idle("hd_out", 5'b00000);
        idle("hd_stay", 5'b00000);

        // reset while halted
        step("rh_req", 1'b0, NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000);
        idle("rh_halt", 5'b00101);
        step("rh_rst", 1'b1, NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);
        idle("rh_after", 5'b00000);

        // reset mid-stall clears the remaining stall cycles
        step("rs_1", 1'b0, use55, lw5, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00100);
        step("rs_rst", 1'b1, NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);
        idle("rs_after", 5'b00000);
        idle("rs_end", 5'b00000);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
